// File: rtl/io_pkg.sv
// Shared definitions for the board-input readers: default sizing and
// the event handshake state encoding.
package io_pkg;

  localparam int SW_WIDTH          = 16;
  localparam int SW_TICK_DIV       = 100000;
  localparam int SW_DEBOUNCE_TICKS = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a tick-paced debounce counter.
module debounce_bit #(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Any sample agreeing with the stable level discards accumulated bounce.
      if (sync_p1 == stable_q) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          stable_q <= sync_p1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sw_input_reader.sv
// Debounced slide-switch reader with change pulse and a single-entry
// change-event handshake for the CPU read path.
module sw_input_reader
  import io_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int TICK_DIV       = SW_TICK_DIV,
  parameter int DEBOUNCE_TICKS = SW_DEBOUNCE_TICKS
) (
  input  logic             CLK100MHZ,
  input  logic             clr,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ack,
  output logic             evt_overrun
);

  localparam int TCW = $clog2(TICK_DIV);

  logic [TCW-1:0]   tcnt;
  logic             tick;
  logic [WIDTH-1:0] stable_p0;
  logic [WIDTH-1:0] stable_p1;
  logic             chg;

  evt_state_t       state, state_n;
  logic [WIDTH-1:0] evt_data_n;
  logic             overrun_n;

  always_ff @(posedge CLK100MHZ) begin
    if (clr) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == TCW'(TICK_DIV - 1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clk    (CLK100MHZ),
      .rst    (clr),
      .tick   (tick),
      .raw    (sw_in[i]),
      .stable (stable_p0[i])
    );
  end

  // Stage p1: previous stable word, so several bits flipping on one tick
  // collapse into a single change.
  always_ff @(posedge CLK100MHZ) begin
    if (clr) begin
      stable_p1  <= '0;
      sw_changed <= 1'b0;
    end else begin
      stable_p1  <= stable_p0;
      sw_changed <= chg;
    end
  end

  assign chg = |(stable_p0 ^ stable_p1);

  always_ff @(posedge CLK100MHZ) begin
    if (clr) begin
      state       <= IDLE;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      evt_data    <= evt_data_n;
      evt_overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    evt_data_n = evt_data;
    overrun_n  = evt_overrun;
    case (state)
      IDLE: begin
        if (chg) begin
          evt_data_n = stable_p0;
          state_n    = PENDING;
        end
      end
      PENDING: begin
        // A simultaneous ack consumes the old event, so the newest one is
        // not an overrun.
        if (chg) begin
          evt_data_n = stable_p0;
          overrun_n  = ~evt_ack;
        end else if (evt_ack) begin
          state_n   = IDLE;
          overrun_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sw_stable = stable_p0;
  assign evt_valid = (state == PENDING);

endmodule

// File: doc/sw_input_reader.md
# sw_input_reader

Board-input side of the FPGA top level: samples the 16 slide switches, synchronizes and debounces each bit, and presents a clean switch word plus a single-entry change-event handshake to the CPU's memory-mapped read path. It is the input-direction counterpart of the seven-segment display driver. The display driver writes CPU results out to the board. This block reads board state in, so the CPU sees glitch-free operands instead of raw `SW` pins.

## Interface
Parameters:
- `WIDTH`, 16: number of switch inputs.
- `TICK_DIV`, 100000: clock cycles per debounce tick (1 ms at 100 MHz); must be ≥2.
- `DEBOUNCE_TICKS`, 10: consecutive mismatching ticks required before a bit flips; must be ≥1.

Ports:
- `CLK100MHZ`, input, 1: the single clock.
- `clr`, input, 1: reset, synchronous, active-high.
- `sw_in`, input, WIDTH: raw asynchronous switch pins.
- `sw_stable`, output, WIDTH: debounced switch word.
- `sw_changed`, output, 1: one-cycle pulse in the cycle after `sw_stable` changes.
- `evt_valid`, output, 1: a change event is pending.
- `evt_data`, output, WIDTH: `sw_stable` snapshot for the pending event.
- `evt_ack`, input, 1: consumer accepts the event. Only meaningful while `evt_valid` is high.
- `evt_overrun`, output, 1: sticky flag. At least one event was overwritten before it was acked.

## Operation
- **Synchronizer.** Each `sw_in` bit passes through a 2-flop synchronizer, giving `sync[i]`. Nothing else samples `sw_in`.
- **Tick generator.** A free-running counter runs 0..TICK_DIV-1 and wraps to 0. `tick` is high for exactly one cycle, in the cycle where the count equals TICK_DIV-1.
- **Per-bit debounce.** Each bit has a counter `cnt[i]` of width clog2(DEBOUNCE_TICKS)+1, evaluated every cycle:
  - If `sync[i]` equals `sw_stable[i]`: `cnt[i]` is set to 0 immediately, without waiting for a tick.
  - Else, on a tick with `cnt[i]` equal to DEBOUNCE_TICKS-1: `sw_stable[i]` is set to `sync[i]` and `cnt[i]` is set to 0.
  - Else, on a tick: `cnt[i]` increments.
  - Between ticks: `cnt[i]` holds.
- **Change detect.** `sw_changed` is registered. It equals 1 in the cycle after any `sw_stable` bit updates. Several bits flipping on the same tick produce one pulse.
- **Event FSM**, with states IDLE and PENDING. `evt_valid` equals (state is PENDING).
  - IDLE, on change: load `evt_data` with the new `sw_stable` and go to PENDING.
  - PENDING, with `evt_ack` and no change: go to IDLE and clear `evt_overrun`.
  - PENDING, with a change and no ack: reload `evt_data` with the newest word, set `evt_overrun`, and stay in PENDING.
  - PENDING, with ack and change in the same cycle: the ack consumes the old event, `evt_data` takes the new word, and the state stays PENDING. `evt_overrun` is cleared, not set.
  - `evt_ack` has no effect in IDLE.
- **Power-up behaviour.** Switches that are already on at reset are reported as a normal change event once their debounce completes.

## Timing
- **Reset values**, in the cycle after `clr` is sampled high:
  - `sw_stable`, `evt_data`, `sync` flops, tick counter and every `cnt[i]` are 0.
  - `sw_changed`, `evt_valid` and `evt_overrun` are 0.
  - The FSM is in IDLE.
- **Reset mid-debounce or mid-event.** All progress is discarded and no event survives.
- **Latency, best case.** From a `sw_in` edge to `sw_stable` is 2 cycles of synchronization plus the time to DEBOUNCE_TICKS ticks. The worst case is 2 + DEBOUNCE_TICKS·TICK_DIV cycles.
- **Downstream of `sw_stable`.**
  - `sw_changed` and `evt_valid` rise 1 cycle after `sw_stable` updates.
  - `evt_data` is valid in the same cycle `evt_valid` rises.
- **Handshake.**
  - `evt_data` is held constant while `evt_valid` is high, except on an overwrite.
  - An ack sampled in cycle n drops `evt_valid` in cycle n+1. The exception is a simultaneous change, where `evt_valid` stays high.
- **Bounce rejection.** A glitch shorter than DEBOUNCE_TICKS ticks returns `cnt[i]` to 0 and produces no output change.

## Structure
- **Package `io_pkg`** holds:
  - The defaults `SW_WIDTH` = 16, `SW_TICK_DIV` = 100000 and `SW_DEBOUNCE_TICKS` = 10.
  - The typedef `evt_state_t` enum {IDLE, PENDING}.
- **Sub-module `debounce_bit`**, instantiated WIDTH times in a generate loop:
  - Contains one synchronizer plus one `cnt`/stable pair.
  - Inputs: `tick` and the raw bit. Output: the stable bit.
- **Top of `sw_input_reader`** contains the tick counter, change detect and event FSM.

## Test plan
The bench uses TICK_DIV=4 and DEBOUNCE_TICKS=3.
- **Reset.** `clr` high for 2 cycles with `sw_in`=16'h0000 → all outputs 0; `evt_valid`=0 for 50 cycles.
- **Clean edge.** Step `sw_in` to 16'h0005 → `sw_stable` becomes 16'h0005 within 2+12 cycles. One `sw_changed` pulse follows. `evt_valid`=1 with `evt_data`=16'h0005. Ack → `evt_valid`=0 next cycle.
- **Bounce.** Toggle bit 3 high for 6 cycles, low for 2, repeated 4 times → `sw_stable` stays unchanged and `evt_valid` stays 0. Then hold bit 3 high → exactly one event, with `evt_data`=16'h0008.
- **Overrun.** With an unacked event for 16'h0001, step to 16'h0003 → `evt_data`=16'h0003, `evt_overrun`=1, `evt_valid` continuous. Ack → `evt_overrun`=0 and `evt_valid`=0.
- **Ack/change collision.** Ack in the exact cycle `sw_stable` changes from 16'h0003 to 16'h0007 → `evt_valid` stays 1, `evt_data`=16'h0007, `evt_overrun`=0.
- **Mid-debounce reset.** Apply `clr` 2 cycles before a pending flip → `sw_stable`=0 and no event. The flip is re-reported 2+12 cycles after reset release.
